// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - MIDI status nibbles, CC numbers, FSM encoding and stamp width shared by the voice allocator
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF      = 4'h8;
  localparam logic [3:0] ST_NOTE_ON       = 4'h9;
  localparam logic [3:0] ST_CTRL          = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;

  localparam int STAMP_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NOTE_ON  = 2'd0,
    OP_NOTE_OFF = 2'd1,
    OP_ALL_OFF  = 2'd2
  } op_t;

endpackage

// File: rtl/voice_age_cmp.sv
// rtl/voice_age_cmp.sv - Flags when stamp_b is strictly older than stamp_a relative to the allocation counter
module voice_age_cmp
  import midi_pkg::*;
(
  input  logic [STAMP_W-1:0] stamp_a,
  input  logic [STAMP_W-1:0] stamp_b,
  input  logic [STAMP_W-1:0] counter,
  output logic               b_older
);

  logic [STAMP_W-1:0] age_a;
  logic [STAMP_W-1:0] age_b;

  // Modular subtraction keeps ages correct across counter wrap.
  always_comb begin
    age_a   = counter - stamp_a;
    age_b   = counter - stamp_b;
    b_older = (age_b > age_a);
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - Polyphonic MIDI voice allocator; define VOICE_STEAL_EN to steal the oldest voice when full
module voice_allocator
  import midi_pkg::*;
#(
  parameter int         NUM_VOICES   = 4,
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input  logic                    clock,
  input  logic                    clr,
  input  logic                    msg_valid,
  input  logic [23:0]             msg_bytes,
  output logic                    msg_ready,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    drop_pulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t state_q, state_d;
  op_t    op_q, op_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] d2_q, d2_d;
  logic       ready_q, ready_d;

  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             match_hit_q, match_hit_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             free_hit_q, free_hit_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic [IDX_W-1:0] old_idx_q, old_idx_d;

  logic [STAMP_W-1:0]    counter_q, counter_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [6:0]            note_q  [NUM_VOICES];
  logic [6:0]            note_d  [NUM_VOICES];
  logic [6:0]            vel_q   [NUM_VOICES];
  logic [6:0]            vel_d   [NUM_VOICES];
  logic [STAMP_W-1:0]    stamp_q [NUM_VOICES];
  logic [STAMP_W-1:0]    stamp_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic                  drop_q, drop_d;

  logic             scan_older;
  logic             alloc;
  logic [IDX_W-1:0] tgt;

  // Data-byte MSBs are meaningless in MIDI and deliberately discarded.
  logic unused_data_msb;
  assign unused_data_msb = msg_bytes[15] ^ msg_bytes[7];

  voice_age_cmp u_age_cmp (
    .stamp_a (stamp_q[old_idx_q]),
    .stamp_b (stamp_q[scan_idx_q]),
    .counter (counter_q),
    .b_older (scan_older)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    status_d    = status_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    ready_d     = ready_q;
    scan_idx_d  = scan_idx_q;
    match_hit_d = match_hit_q;
    match_idx_d = match_idx_q;
    free_hit_d  = free_hit_q;
    free_idx_d  = free_idx_q;
    old_idx_d   = old_idx_q;
    counter_d   = counter_q;
    active_d    = active_q;
    note_d      = note_q;
    vel_d       = vel_q;
    stamp_d     = stamp_q;
    trig_d      = '0;
    drop_d      = 1'b0;
    alloc       = 1'b0;
    tgt         = '0;

    case (state_q)
      IDLE: begin
        if (msg_valid && ready_q) begin
          status_d = msg_bytes[23:16];
          d1_d     = msg_bytes[14:8];
          d2_d     = msg_bytes[6:0];
          ready_d  = 1'b0;
          state_d  = DECODE;
        end
      end

      DECODE: begin
        scan_idx_d  = '0;
        match_hit_d = 1'b0;
        free_hit_d  = 1'b0;
        old_idx_d   = '0;
        state_d     = IDLE;
        ready_d     = 1'b1;
        if (status_q[3:0] == MIDI_CHANNEL) begin
          if (status_q[7:4] == ST_NOTE_ON && d2_q != 7'd0) begin
            op_d    = OP_NOTE_ON;
            state_d = SCAN;
            ready_d = 1'b0;
          end else if (status_q[7:4] == ST_NOTE_ON || status_q[7:4] == ST_NOTE_OFF) begin
            op_d    = OP_NOTE_OFF;
            state_d = SCAN;
            ready_d = 1'b0;
          end else if (status_q[7:4] == ST_CTRL && d1_q == CC_ALL_NOTES_OFF) begin
            op_d    = OP_ALL_OFF;
            state_d = COMMIT;
            ready_d = 1'b0;
          end
        end
      end

      SCAN: begin
        if (active_q[scan_idx_q] && note_q[scan_idx_q] == d1_q && !match_hit_q) begin
          match_hit_d = 1'b1;
          match_idx_d = scan_idx_q;
        end
        if (!active_q[scan_idx_q] && !free_hit_q) begin
          free_hit_d = 1'b1;
          free_idx_d = scan_idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (scan_older) begin
          old_idx_d = scan_idx_q;
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        ready_d = 1'b1;
        case (op_q)
          OP_ALL_OFF: active_d = '0;
          OP_NOTE_OFF: begin
            if (match_hit_q) begin
              active_d[match_idx_q] = 1'b0;
            end
          end
          default: begin
            if (match_hit_q) begin
              alloc = 1'b1;
              tgt   = match_idx_q;
            end else if (free_hit_q) begin
              alloc = 1'b1;
              tgt   = free_idx_q;
            end else begin
`ifdef VOICE_STEAL_EN
              alloc = 1'b1;
              tgt   = old_idx_q;
`else
              drop_d = 1'b1;
`endif
            end
          end
        endcase
        if (alloc) begin
          active_d[tgt] = 1'b1;
          note_d[tgt]   = d1_q;
          vel_d[tgt]    = d2_q;
          stamp_d[tgt]  = counter_q;
          counter_d     = counter_q + 1'b1;
          trig_d[tgt]   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q     <= IDLE;
      op_q        <= OP_NOTE_ON;
      status_q    <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      ready_q     <= 1'b1;
      scan_idx_q  <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      counter_q   <= '0;
      active_q    <= '0;
      trig_q      <= '0;
      drop_q      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v]  <= '0;
        vel_q[v]   <= '0;
        stamp_q[v] <= '0;
      end
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      status_q    <= status_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      ready_q     <= ready_d;
      scan_idx_q  <= scan_idx_d;
      match_hit_q <= match_hit_d;
      match_idx_q <= match_idx_d;
      free_hit_q  <= free_hit_d;
      free_idx_q  <= free_idx_d;
      old_idx_q   <= old_idx_d;
      counter_q   <= counter_d;
      active_q    <= active_d;
      trig_q      <= trig_d;
      drop_q      <= drop_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      stamp_q     <= stamp_d;
    end
  end

  always_comb begin
    msg_ready    = ready_q;
    voice_active = active_q;
    voice_trig   = trig_q;
    drop_pulse   = drop_q;
    voice_note   = '0;
    voice_vel    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note[7*v +: 7] = note_q[v];
      voice_vel[7*v +: 7]  = vel_q[v];
    end
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4 (range 2..16), which is the number of synthesizer voice slots.
REQ-002 SHALL have parameter MIDI_CHANNEL, default 4'd0, which is the only MIDI channel accepted.
REQ-003 SHALL have port clock, input, 1 bit, the single system clock.
REQ-004 SHALL have port clr, input, 1 bit, the reset (synchronous, active-high).
REQ-005 SHALL have port msg_valid, input, 1 bit, meaning msg_bytes holds a complete MIDI message.
REQ-006 SHALL have port msg_bytes, input, 24 bits, the message: [23:16] status, [15:8] data1, [7:0] data2.
REQ-007 SHALL have port msg_ready, output, 1 bit, meaning the block accepts a message this cycle.
REQ-008 SHALL have port voice_active, output, NUM_VOICES bits, holding the per-voice gate.
REQ-009 SHALL have port voice_note, output, 7*NUM_VOICES bits, holding the note number of voice v at [7v+6:7v].
REQ-010 SHALL have port voice_vel, output, 7*NUM_VOICES bits, holding the velocity of voice v at [7v+6:7v].
REQ-011 SHALL have port voice_trig, output, NUM_VOICES bits, a one-cycle pulse on (re)allocation of voice v.
REQ-012 SHALL have port drop_pulse, output, 1 bit, a one-cycle pulse when a note-on is discarded.

Function
REQ-013 SHALL accept a message on a cycle where msg_valid && msg_ready; msg_bytes SHALL be captured on that edge.
REQ-014 SHALL use FSM states IDLE, DECODE, SCAN and COMMIT; msg_ready SHALL be 1 only in IDLE.
REQ-015 SHALL move IDLE->DECODE on accept; DECODE->SCAN for note-on/note-off; DECODE->COMMIT for all-notes-off; DECODE->IDLE for an ignored message.
REQ-016 SHALL have SCAN examine one voice per cycle, indices 0..NUM_VOICES-1, then go to COMMIT; COMMIT SHALL go to IDLE.
REQ-017 SHALL give a note message a latency of NUM_VOICES+2 cycles from accept to output update; msg_ready SHALL return on the following cycle.
REQ-018 SHALL classify status 0x9c with data2!=0 as note-on, where c=MIDI_CHANNEL.
REQ-019 SHALL classify status 0x8c, or 0x9c with data2==0, as note-off.
REQ-020 SHALL classify status 0xBc with data1==0x7B as all-notes-off.
REQ-021 SHALL ignore all other messages: a status with bit7==0, any other channel, or any other type.
REQ-022 SHALL use data1[6:0] as the note and data2[6:0] as the velocity, and SHALL ignore bit 7 of data bytes.
REQ-023 SHALL, on note-on whose note is already active on voice v, reuse voice v: update vel, restamp age, pulse voice_trig[v].
REQ-024 SHALL, on note-on otherwise, allocate the lowest-index inactive voice.
REQ-025 SHALL, on note-on with all voices active, follow the configuration in REQ-034/REQ-035.
REQ-026 SHALL, on note-off, clear voice_active of the voice holding that note; if none matches, nothing changes and no pulse is generated.
REQ-027 SHALL, on all-notes-off, clear all voice_active bits; voice_note and voice_vel SHALL be kept.
REQ-028 SHALL keep an 8-bit allocation counter that increments on every allocation and wraps at 255->0.
REQ-029 SHALL, on each allocation, copy the allocation counter into the chosen voice's stamp.
REQ-030 SHALL define the oldest voice as the one with maximum (counter - stamp) mod 256; ties SHALL go to the lowest index.
REQ-031 SHALL assert voice_trig and drop_pulse for exactly the one cycle after COMMIT; all outputs are registered.

Reset
REQ-032 SHALL, when clr is sampled high, set state=IDLE, msg_ready=1, and voice_active, voice_note, voice_vel, voice_trig, drop_pulse, stamps and the counter to 0.
REQ-033 SHALL, on clr mid-operation (DECODE/SCAN/COMMIT), abandon the in-flight message with no output update; clr SHALL take priority over accept.

Configuration
REQ-034 SHALL, with VOICE_STEAL_EN defined, on note-on with all voices active, steal the oldest voice: overwrite note/vel, restamp, pulse voice_trig.
REQ-035 SHALL, without VOICE_STEAL_EN, on note-on with all voices active, leave voices unchanged and pulse drop_pulse.

Structure
REQ-036 SHALL place the status nibbles (0x8, 0x9, 0xB), the CC number 0x7B, the FSM state encoding and the stamp width in shared package midi_pkg.
REQ-037 SHALL put the oldest-voice comparison in sub-module voice_age_cmp (two stamps plus counter in, older-select out).

Verification
REQ-038 SHALL verify: 0x903C64 accepted -> after 6 cycles (N=4) voice0 active, note 0x3C, vel 0x64, voice_trig=4'b0001 for one cycle.
REQ-039 SHALL verify: note-ons 0x3C, 0x40, 0x43, 0x48, then 0x803C -> voices 0..3 allocated in order, then voice_active=4'b1110.
REQ-040 SHALL verify: four voices active, then 0x904C50 -> with VOICE_STEAL_EN voice0 gets note 0x4C and trig; without it voices are unchanged and drop_pulse=1.
REQ-041 SHALL verify: 0x903C64 then 0x903C20 -> one voice is active, vel 0x20, voice_trig pulses twice on the same bit.
REQ-042 SHALL verify: 0x913C64 (channel 1), 0x3C6400 (no status bit) and 0xB07B00 -> first two change nothing; third clears voice_active.
REQ-043 SHALL verify: clr pulsed during SCAN of a note-on -> all outputs 0 and msg_ready=1 the next cycle.
